reg_delay_var: RTL and testbench
================================

// Module: reg_delay_var
// PURPOSE
//  Parametrised, stallable delay line: successor to the fixed two-register delays used to
//  align operand and residue-digit paths in the TPU datapath. DEPTH registered stages carry a
//  data word plus a valid bit. A run-time tap select sets the latency to 1..DEPTH cycles.
//  Clock-enable stall and flush let the line track a stalling pipeline without losing alignment.
// PARAMETERS
//  DATA_WIDTH    18  width of reg_in / reg_out, bits (>=1)
//  DEPTH          2  number of register stages, maximum latency in cycles (>=1)
//  ZERO_INVALID   0  1: reg_out forced to 0 while valid_out=0; 0: raw stage data is passed
//  TAP_W          derived, not set by the user: DEPTH>1 ? $clog2(DEPTH) : 1
// PORTS
//  clk        in   1           rising-edge clock; the only clock
//  reset      in   1           synchronous, active-high reset
//  en         in   1           shift enable; 0 = every stage holds
//  flush      in   1           synchronous clear of all stages (data and valid)
//  tap_sel    in   TAP_W       output tap; latency = tap_sel+1 cycles
//  reg_in     in   DATA_WIDTH  input data word
//  valid_in   in   1           qualifies reg_in
//  reg_out    out  DATA_WIDTH  data from the selected stage
//  valid_out  out  1           valid bit from the selected stage
// BEHAVIOUR
//  - Storage: stage[0..DEPTH-1], each holding {valid, data}. stage[0] is nearest the input.
//  - Edge priority: reset > flush > en > hold.
//  - reset=1 at an edge: every stage gets data=0, valid=0.
//    Output after reset: reg_out=0, valid_out=0, for any tap_sel.
//  - flush=1 (reset=0): same clear as reset. en and valid_in are ignored that cycle, so the
//    input word presented that cycle is dropped.
//  - en=1: stage[0] <= {valid_in, reg_in}; stage[k] <= stage[k-1] for k=1..DEPTH-1.
//    The input is captured regardless of valid_in. Data and valid always move together.
//  - en=0: all stages hold. The input is ignored.
//  - Output is a combinational mux on the registered stages: {valid_out, reg_out} = stage[t].
//    - t = tap_sel, clamped to DEPTH-1 when tap_sel >= DEPTH.
//    - No combinational path from reg_in or valid_in to the outputs.
//  - Latency: with en held at 1, a word presented at edge n appears at the output after
//    edge n+tap_sel. Each en=0 cycle adds one cycle.
//  - tap_sel change: the output switches to the new tap in the same cycle.
//    - Shortening the tap skips the words in between.
//    - Lengthening it repeats words already output.
//    - There is no protection; the upstream controller changes tap_sel only while the line
//      is flushed or idle.
//  - ZERO_INVALID=1: reg_out = valid_out ? stage[t].data : 0. valid_out is unaffected.
//  - DEPTH=1: tap_sel is ignored. The block is one register with enable, flush and valid.
//  - A stage implementation (per-stage enable registers) is acceptable only if it is cycle-
//    identical to the above. No reset-value dependence beyond the values stated above.
// TESTING
//  T1 reset: DEPTH=4, random stage contents, assert reset for 1 cycle
//     -> valid_out=0 and reg_out=0 for tap_sel=0..3.
//  T2 latency sweep: DEPTH=4, en=1, stream 0x00001,0x00002,... with valid_in=1, tap_sel=0..3
//     -> word k appears tap_sel cycles after its edge, with valid_out=1.
//  T3 stall: DEPTH=4, tap_sel=3, en low for 2 cycles mid-stream -> output sequence unchanged,
//     each word delayed exactly 2 extra cycles, no word duplicated or lost.
//  T4 flush vs en: flush=1 and en=1 with valid_in=1, reg_in=0x2AAAA -> next cycle valid_out=0
//     at every tap. 0x2AAAA never appears; reset+flush together behaves as reset.
//  T5 valid bubbles: alternate valid_in 1/0 with tap_sel=2
//     -> valid_out reproduces the pattern 3 cycles later.
//     With ZERO_INVALID=1, reg_out=0 on every bubble.
//  T6 clamp: DEPTH=3 (TAP_W=2), tap_sel=3 -> output identical to tap_sel=2, latency 3.

Source files
------------

// File: rtl/reg_delay_var.sv
// Stallable, flushable delay line with a run-time output tap.
// DEPTH stages each carry {valid, data}. The output is a mux over the registered stages,
// so the latency is tap_sel+1 cycles and there is no combinational input-to-output path.
module reg_delay_var #(
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned ZERO_INVALID = 0,
  localparam int unsigned TAP_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic [TAP_W-1:0]      tap_sel,
  input  logic [DATA_WIDTH-1:0] reg_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] reg_out,
  output logic                  valid_out
);

  // Stage 0 is nearest the input.
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  logic [TAP_W-1:0]      w_tap;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_valid;

  // Stage registers: reset and flush clear everything, en shifts, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_valid <= '0;
    end else if (flush) begin
      // The word presented alongside a flush is dropped.
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_valid <= '0;
    end else if (en) begin
      r_data[0]  <= reg_in;
      r_valid[0] <= valid_in;
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k]  <= r_data[k-1];
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  // Tap select, clamped to the last stage when it points past the end.
  always_comb begin
    w_tap = tap_sel;
    if (DEPTH == 1) begin
      w_tap = '0;
    end else if (32'(tap_sel) >= DEPTH) begin
      w_tap = TAP_W'(DEPTH - 1);
    end
  end

  // Output mux; data optionally zeroed while the selected stage is invalid.
  always_comb begin
    w_data    = r_data[w_tap];
    w_valid   = r_valid[w_tap];
    valid_out = w_valid;
    reg_out   = w_data;
    if ((ZERO_INVALID != 0) && !w_valid) begin
      reg_out = '0;
    end
  end

endmodule

// File: tb/tb_reg_delay_var.sv
// Directed bench for reg_delay_var: a DEPTH=4 raw-data instance and a DEPTH=3
// ZERO_INVALID instance share the same stimulus.
module tb_reg_delay_var;

  localparam int unsigned DW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          flush;
  logic [1:0]    tap_sel;
  logic [DW-1:0] reg_in;
  logic          valid_in;

  logic [DW-1:0] d4_out;
  logic          d4_vld;
  logic [DW-1:0] d3_out;
  logic          d3_vld;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-written stall scenario at tap 3: en pattern and expected output word per cycle.
  logic t3_en  [13] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  int   t3_exp [13] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};

  int   exp_d;
  logic exp_v;
  int   w;

  always #5 clk = ~clk;

  reg_delay_var #(
    .DATA_WIDTH   (DW),
    .DEPTH        (4),
    .ZERO_INVALID (0)
  ) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .tap_sel   (tap_sel),
    .reg_in    (reg_in),
    .valid_in  (valid_in),
    .reg_out   (d4_out),
    .valid_out (d4_vld)
  );

  reg_delay_var #(
    .DATA_WIDTH   (DW),
    .DEPTH        (3),
    .ZERO_INVALID (1)
  ) u_dut3z (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .tap_sel   (tap_sel),
    .reg_in    (reg_in),
    .valid_in  (valid_in),
    .reg_out   (d3_out),
    .valid_out (d3_vld)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    en    = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; tap_sel = 2'd0; reg_in = '0; valid_in = 1'b0;
    step();
    step();
    reset = 1'b0;

    // T1: random contents, then one reset cycle clears every tap.
    en = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reg_in = DW'($urandom) | DW'(1);
      step();
    end
    en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t);
      #1;
      check($sformatf("t1_d4_valid_tap%0d", t), 32'(d4_vld), 32'd0);
      check($sformatf("t1_d4_data_tap%0d", t), 32'(d4_out), 32'd0);
      check($sformatf("t1_d3_valid_tap%0d", t), 32'(d3_vld), 32'd0);
    end

    // T2: latency sweep on the DEPTH=4 line.
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t);
      do_flush();
      en = 1'b1; valid_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
        reg_in = DW'(i + 1);
        step();
        exp_d = (i >= t) ? (i - t + 1) : 0;
        exp_v = (i >= t);
        check($sformatf("t2_data_tap%0d_c%0d", t, i), 32'(d4_out), 32'(exp_d));
        check($sformatf("t2_valid_tap%0d_c%0d", t, i), 32'(d4_vld), 32'(exp_v));
      end
    end

    // T3: two stall cycles at tap 3; junk offered during the stall must be ignored.
    tap_sel = 2'd3;
    do_flush();
    w = 0;
    for (int i = 0; i < 13; i++) begin
      en       = t3_en[i];
      valid_in = 1'b1;
      if (t3_en[i]) begin
        w++;
        reg_in = DW'(w);
      end else begin
        reg_in = '1;
      end
      step();
      check($sformatf("t3_data_c%0d", i), 32'(d4_out), 32'(t3_exp[i]));
      check($sformatf("t3_valid_c%0d", i), 32'(d4_vld), 32'(t3_exp[i] != 0));
    end

    // T4: flush beats en; the word offered with the flush never enters.
    tap_sel = 2'd0;
    do_flush();
    en = 1'b1; valid_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      reg_in = DW'(i);
      step();
    end
    flush = 1'b1; reg_in = 18'h2AAAA;
    step();
    flush = 1'b0; en = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t);
      #1;
      check($sformatf("t4_valid_tap%0d", t), 32'(d4_vld), 32'd0);
      check($sformatf("t4_data_tap%0d", t), 32'(d4_out), 32'd0);
    end
    step();
    tap_sel = 2'd0;
    #1;
    check("t4_hold_data", 32'(d4_out), 32'd0);
    en = 1'b1; reg_in = DW'(5);
    step();
    check("t4_new_data_tap0", 32'(d4_out), 32'd5);
    check("t4_new_valid_tap0", 32'(d4_vld), 32'd1);
    tap_sel = 2'd1;
    #1;
    check("t4_no_aaaa_tap1", 32'(d4_out), 32'd0);
    check("t4_no_aaaa_valid_tap1", 32'(d4_vld), 32'd0);
    reg_in = DW'(6);
    step();
    reg_in = DW'(7);
    step();
    reset = 1'b1; flush = 1'b1; en = 1'b1; reg_in = 18'h2AAAA;
    step();
    reset = 1'b0; flush = 1'b0; en = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t);
      #1;
      check($sformatf("t4_rstflush_valid_tap%0d", t), 32'(d4_vld), 32'd0);
      check($sformatf("t4_rstflush_data_tap%0d", t), 32'(d4_out), 32'd0);
    end

    // T5: alternating valid at tap 2; raw data on DEPTH=4, zeroed bubbles on DEPTH=3.
    tap_sel = 2'd2;
    do_flush();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_in = ((i % 2) == 0);
      reg_in   = DW'(32'h100 + i);
      step();
      exp_v = (i >= 2) && ((i % 2) == 0);
      exp_d = (i >= 2) ? (32'h100 + i - 2) : 0;
      check($sformatf("t5_d4_valid_c%0d", i), 32'(d4_vld), 32'(exp_v));
      check($sformatf("t5_d4_data_c%0d", i), 32'(d4_out), 32'(exp_d));
      check($sformatf("t5_d3_valid_c%0d", i), 32'(d3_vld), 32'(exp_v));
      check($sformatf("t5_d3_data_c%0d", i), 32'(d3_out), exp_v ? 32'(exp_d) : 32'd0);
    end

    // T6: tap 3 on the DEPTH=3 line clamps to tap 2 (latency 3); DEPTH=4 keeps latency 4.
    tap_sel = 2'd3;
    do_flush();
    en = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tap_sel = 2'd3;
      reg_in  = DW'(32'h200 + i);
      step();
      exp_d = (i >= 2) ? (32'h200 + i - 2) : 0;
      check($sformatf("t6_d3_tap3_c%0d", i), 32'(d3_out), 32'(exp_d));
      check($sformatf("t6_d3_tap3_valid_c%0d", i), 32'(d3_vld), 32'(i >= 2));
      check($sformatf("t6_d4_tap3_c%0d", i), 32'(d4_out), (i >= 3) ? (32'h200 + i - 3) : 32'd0);
      tap_sel = 2'd2;
      #1;
      check($sformatf("t6_d3_tap2_c%0d", i), 32'(d3_out), 32'(exp_d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
